// File: rtl/handshaking_master_if.sv
// Valid/ready link bundle between a word producer and its sink.
// master: drives data_out/data_valid, reads data_in/data_ready; slave mirrors.
interface handshaking_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    input  data_in,
    input  data_ready,
    output data_out,
    output data_valid
  );

  modport slave (
    output data_in,
    output data_ready,
    input  data_out,
    input  data_valid
  );
endinterface

// File: rtl/handshaking_master.sv
// Source-side valid/ready controller: samples data_in in IDLE, holds it in SEND.
// Ports: clk, rst (async active-low), bus (master modport of the link bundle).
module handshaking_master #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  handshaking_master_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Outputs are pure register copies; no input reaches them combinationally.
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          data_q  <= bus.data_in;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          // A non-1 ready (0 or X) takes the hold path.
          if (bus.data_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshaking_master.sv
// Randomized scoreboard bench for handshaking_master.
// A transaction-level link model predicts words and valid; a monitor checks transfers.
module tb_handshaking_master;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   n_acc;
  logic [7:0] expq[$];
  logic [7:0] acc_log[$];

  bit         m_pend;
  logic [7:0] m_out;

  handshaking_master_if #(.DATA_WIDTH(8)) bus ();

  handshaking_master #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Link model: after reset or a completed transfer the next edge loads a
  // fresh word; a loaded word stays until an edge sees ready==1.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      chk("rst_valid", {31'd0, bus.data_valid}, 32'd0);
      chk("rst_out", {24'd0, bus.data_out}, 32'd0);
      m_pend = 1'b0;
      m_out  = 8'h00;
      expq.delete();
    end else begin
      chk("valid", {31'd0, bus.data_valid}, {31'd0, m_pend});
      chk("out", {24'd0, bus.data_out}, {24'd0, m_out});
      if (!m_pend) begin
        m_out  = bus.data_in;
        m_pend = 1'b1;
        expq.push_back(bus.data_in);
      end else if (bus.data_ready === 1'b1) begin
        m_pend = 1'b0;
      end
    end
  end

  // Monitor: every transfer the DUT offers must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.data_valid === 1'b1
        && bus.data_ready === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL xfer_unexpected: got %h expected none at %0t",
                 bus.data_out, $time);
      end else begin
        chk("xfer_word", {24'd0, bus.data_out}, {24'd0, expq.pop_front()});
      end
      acc_log.push_back(bus.data_out);
      n_acc++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (bus.data_valid !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    if (k >= 20) begin
      total++;
      $display("FAIL %s: got timeout expected data_valid=1", name);
    end
  endtask

  initial begin
    int base;
    int k;
    passed = 0;
    total  = 0;
    n_acc  = 0;
    m_pend = 1'b0;
    m_out  = 8'h00;

    // Reset held: outputs zero between edges too.
    rst            = 1'b0;
    bus.data_in    = 8'h96;
    bus.data_ready = 1'b0;
    #1;
    chk("reset_out_t0", {24'd0, bus.data_out}, 32'd0);
    step(3);
    chk("reset_valid_mid", {31'd0, bus.data_valid}, 32'd0);
    chk("reset_out_mid", {24'd0, bus.data_out}, 32'd0);

    // Stall then accept.
    rst = 1'b1;
    step(1);
    chk("first_valid", {31'd0, bus.data_valid}, 32'd1);
    chk("first_out", {24'd0, bus.data_out}, 32'h96);
    step(4);
    chk("stall_valid", {31'd0, bus.data_valid}, 32'd1);
    bus.data_ready = 1'b1;
    step(1);
    chk("accept_drop", {31'd0, bus.data_valid}, 32'd0);
    chk("accept_keep", {24'd0, bus.data_out}, 32'h96);
    chk("accept_count", n_acc, 32'd1);

    // Streaming: switch input after the third handshake.
    acc_log.delete();
    base = n_acc;
    k = 0;
    while (n_acc - base < 3 && k < 20) begin
      step(1);
      k++;
    end
    chk("stream_hs3", {31'd0, (n_acc - base) == 3}, 32'd1);
    bus.data_in = 8'h69;
    step(8);
    chk("stream_n", {31'd0, acc_log.size() >= 6}, 32'd1);
    for (int i = 0; i < 3; i++)
      chk("stream_w96", {24'd0, acc_log[i]}, 32'h96);
    for (int i = 3; i < 6; i++)
      chk("stream_w69", {24'd0, acc_log[i]}, 32'h69);

    // Input change during stall.
    bus.data_ready = 1'b0;
    bus.data_in    = 8'h96;
    step(2);
    wait_valid("stall_wait");
    bus.data_in = 8'h69;
    step(3);
    chk("stall_hold", {24'd0, bus.data_out}, {24'd0, m_out});
    bus.data_ready = 1'bx;
    step(2);
    chk("x_notready", {31'd0, bus.data_valid}, 32'd1);
    bus.data_ready = 1'b1;
    step(1);
    bus.data_ready = 1'b0;
    step(2);
    chk("stall_next", {24'd0, bus.data_out}, 32'h69);

    // Asynchronous reset mid-transfer.
    wait_valid("arst_wait");
    chk("arst_pre", {31'd0, bus.data_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("arst_out", {24'd0, bus.data_out}, 32'd0);
    step(2);
    bus.data_in = 8'h3c;
    rst = 1'b1;
    #1;
    chk("arst_rel", {31'd0, bus.data_valid}, 32'd0);
    step(1);
    chk("arst_restart", {24'd0, bus.data_out}, 32'h3c);

    // Ready pulsed only in IDLE: accept, stay high through IDLE, then drop.
    bus.data_ready = 1'b1;
    step(1);
    chk("idle_in", {31'd0, bus.data_valid}, 32'd0);
    base = n_acc;
    step(1);
    bus.data_ready = 1'b0;
    step(3);
    chk("idle_noacc", n_acc, base);
    chk("idle_wait", {31'd0, bus.data_valid}, 32'd1);
    bus.data_ready = 1'b1;
    step(1);
    bus.data_ready = 1'b0;

    // Randomized traffic, including X on ready.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 3));
      bus.data_ready = (k == 0) ? 1'bx : ((k == 1) ? 1'b0 : 1'b1);
      bus.data_in    = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        chk("rand_arst", {31'd0, bus.data_valid}, 32'd0);
        step(1);
        rst = 1'b1;
      end
      step(1);
    end
    bus.data_ready = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
